// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

   localparam int DATA_W_DEF    = 32;
   localparam int ADDR_W_DEF    = 32;
   localparam int MEM_DEPTH_DEF = 128;

   // Transaction sequencer states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   // Requester index: 0 = load/store port, 1 = debug/DMA port.
   typedef logic port_idx_t;

   // Convert a one-hot grant into a port index (port 1 only when gnt is exactly 2'b10).
   function automatic port_idx_t onehot_to_idx(input logic [1:0] gnt);
      return (gnt == 2'b10) ? 1'b1 : 1'b0;
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin grant, purely combinational.
// On a tie the port that did not win last time is granted.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  port_idx_t  last_grant,
   output logic [1:0] gnt
);

   // Single requester passes straight through; a tie goes to the other port.
   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = (last_grant == 1'b1) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-cycle data memory.
// Every access runs IDLE -> ACCESS -> RESP, so the memory sees exactly one
// strobe per transaction and every output comes straight from a flop.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for a request; grant and latch the winner's command
//   ACCESS | strobe presented to memory (suppressed when out of range)
//   RESP   | ack/err pulse on the granted port; requests are ignored
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,
   output logic              p0_err,

   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              p1_err,

   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata
);

   // One extra bit so the range compare never truncates the address or depth.
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);

   arb_state_e                 state_q, state_d;
   port_idx_t                  last_grant_q, last_grant_d;
   port_idx_t                  gnt_port_q, gnt_port_d;

   logic                       lat_we_q, lat_we_d;
   logic [ADDR_W-1:0]          lat_addr_q, lat_addr_d;
   logic [DATA_W-1:0]          lat_wdata_q, lat_wdata_d;
   logic                       in_range_q, in_range_d;

   logic                       mem_we_q, mem_we_d;
   logic                       mem_re_q, mem_re_d;

   logic [1:0]                 ack_q, ack_d;
   logic [1:0]                 err_q, err_d;
   logic [1:0][DATA_W-1:0]     rdata_q, rdata_d;

   logic [1:0]                 req_vec;
   logic [1:0]                 gnt;
   port_idx_t                  sel;
   logic                       sel_we;
   logic [ADDR_W-1:0]          sel_addr;
   logic [DATA_W-1:0]          sel_wdata;
   logic                       sel_in_range;

   assign req_vec = {p1_req, p0_req};

   rr_arb2 u_rr_arb2 (
      .req        (req_vec),
      .last_grant (last_grant_q),
      .gnt        (gnt)
   );

   // Mux the winning requester's command so it can be latched in IDLE.
   always_comb begin
      sel          = onehot_to_idx(gnt);
      sel_we       = sel ? p1_we    : p0_we;
      sel_addr     = sel ? p1_addr  : p0_addr;
      sel_wdata    = sel ? p1_wdata : p0_wdata;
      sel_in_range = ({1'b0, sel_addr} < DEPTH_EXT);
   end

   // Next-state and next-output logic for the three-state sequencer.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      gnt_port_d   = gnt_port_q;
      lat_we_d     = lat_we_q;
      lat_addr_d   = lat_addr_q;
      lat_wdata_d  = lat_wdata_q;
      in_range_d   = in_range_q;
      rdata_d      = rdata_q;
      mem_we_d     = 1'b0;
      mem_re_d     = 1'b0;
      ack_d        = 2'b00;
      err_d        = 2'b00;

      case (state_q)
         IDLE: begin
            if (|req_vec) begin
               state_d      = ACCESS;
               gnt_port_d   = sel;
               last_grant_d = sel;
               lat_we_d     = sel_we;
               lat_addr_d   = sel_addr;
               lat_wdata_d  = sel_wdata;
               in_range_d   = sel_in_range;
               // Strobe is registered here so it is live for the whole ACCESS cycle.
               mem_we_d     = sel_we  & sel_in_range;
               mem_re_d     = !sel_we & sel_in_range;
            end
         end

         ACCESS: begin
            state_d            = RESP;
            ack_d[gnt_port_q]  = 1'b1;
            err_d[gnt_port_q]  = !in_range_q;
            if (!in_range_q) begin
               rdata_d[gnt_port_q] = '0;
            end else if (!lat_we_q) begin
               rdata_d[gnt_port_q] = mem_rdata;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any in-flight transaction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         gnt_port_q   <= 1'b0;
         lat_we_q     <= 1'b0;
         lat_addr_q   <= '0;
         lat_wdata_q  <= '0;
         in_range_q   <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_re_q     <= 1'b0;
         ack_q        <= 2'b00;
         err_q        <= 2'b00;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         gnt_port_q   <= gnt_port_d;
         lat_we_q     <= lat_we_d;
         lat_addr_q   <= lat_addr_d;
         lat_wdata_q  <= lat_wdata_d;
         in_range_q   <= in_range_d;
         mem_we_q     <= mem_we_d;
         mem_re_q     <= mem_re_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         rdata_q      <= rdata_d;
      end
   end

   assign mem_addr  = lat_addr_q;
   assign mem_wdata = lat_wdata_q;
   assign mem_we    = mem_we_q;
   assign mem_re    = mem_re_q;

   assign p0_ack    = ack_q[0];
   assign p1_ack    = ack_q[1];
   assign p0_err    = err_q[0];
   assign p1_err    = err_q[1];
   assign p0_rdata  = rdata_q[0];
   assign p1_rdata  = rdata_q[1];

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-cycle data memory. It shares the memory between the processor load/store port (port 0) and a debug/DMA port (port 1) using round-robin arbitration. Each access runs as a registered three-state transaction, so exactly one MemRead or MemWrite strobe reaches the memory per transaction. The block sits between the requesters and the Data_Memory instance and drives all of that memory's inputs.

## Interface
- DATA_W, 32, data width of both ports and the memory.
- ADDR_W, 32, address width (word index, as the memory uses).
- MEM_DEPTH, 128, number of memory words; addresses ≥ MEM_DEPTH are rejected.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- p0_req, p1_req  in  1  access request; held high until the matching ack.
- p0_we, p1_we  in  1  1 = write, 0 = read; stable while req is high.
- p0_addr, p1_addr  in  ADDR_W  word address; stable while req is high.
- p0_wdata, p1_wdata  in  DATA_W  store data; stable while req is high.
- p0_ack, p1_ack  out  1  one-cycle completion pulse.
- p0_rdata, p1_rdata  out  DATA_W  load data; valid in the ack cycle and held until the next ack on that port.
- p0_err, p1_err  out  1  out-of-range flag; valid in the ack cycle only.
- mem_addr  out  ADDR_W  to Address.
- mem_wdata  out  DATA_W  to Write_Data.
- mem_we  out  1  to MemWrite.
- mem_re  out  1  to MemRead.
- mem_rdata  in  DATA_W  from Read_Data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If no req is high, stay in IDLE.
  - Otherwise grant a port and latch its we/addr/wdata into internal registers.
  - Go to ACCESS.
- **Arbitration**
  - With one req high, that port wins.
  - With both high, the port not granted last wins.
  - last_grant updates on each grant. Its reset value is 1, so port 0 wins the first tie.
- **ACCESS** (exactly one cycle)
  - mem_addr = latched addr; mem_wdata = latched wdata.
  - mem_we = latched we and in-range; mem_re = !latched we and in-range.
  - In-range means addr < MEM_DEPTH, compared at full ADDR_W width with no truncation.
  - At the end of ACCESS, capture mem_rdata into the granted port's rdata register (reads only), then go to RESP.
- **RESP** (exactly one cycle)
  - The granted port's ack = 1.
  - err = 1 if the address was out of range. In that case no strobe was issued and rdata is set to 0.
  - Go to IDLE.
  - All reqs are ignored in RESP.
- mem_we and mem_re are never both 1. Both are 0 in IDLE and RESP.
- Writes return ack with err = 0 and leave that port's rdata unchanged.
- Requester rule: deassert req, or present a new request, in the cycle after ack. A req still high in IDLE is treated as a new request.
- A req dropped before ack is a protocol violation. The arbiter still completes the transaction it has latched.

## Timing
- Latency: req sampled high in IDLE at edge k → strobe during cycle k+1 → ack during cycle k+2.
- Throughput: one access per 3 cycles with back-to-back requests.
- With both ports requesting continuously, grants alternate; each port completes every 6 cycles.
- All outputs are registered: ack, err, rdata and the mem_* signals come from flops.
- Reset asserted at any time, including mid-transaction:
  - state = IDLE, last_grant = 1.
  - All ack/err/mem_we/mem_re = 0; mem_addr, mem_wdata and rdata = 0.
  - An in-flight transaction is dropped with no ack.
- Reset release: the first req can be sampled at the first rising edge with reset = 1.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum {IDLE, ACCESS, RESP};
  - the port-index type (1 bit);
  - default constants for DATA_W, ADDR_W, MEM_DEPTH.
- Sub-module rr_arb2 is a pure-combinational 2-requester round-robin grant. Inputs: req[1:0], last_grant. Output: one-hot gnt[1:0].
- The top level holds the FSM, the latch registers, the rdata/ack/err registers and the mem_* drivers.

## Test plan
- After reset, p0 reads addr 5 (memory preloaded to i+10) → mem_re high exactly one cycle, p0_ack 2 cycles after the sampling edge, p0_rdata = 15, p0_err = 0.
- p1 writes 0xDEADBEEF to addr 20, then p1 reads addr 20 → exactly one mem_we pulse with mem_addr = 20; read returns 0xDEADBEEF.
- p0 and p1 raise req in the same cycle and hold continuously → grant order p0, p1, p0, p1; acks 3 cycles apart; no cycle has both mem_we and mem_re high.
- p0 reads addr 128, then addr 0xFFFF_FFFF → no mem_re/mem_we pulse; p0_ack with p0_err = 1 and p0_rdata = 0 for each.
- Assert reset during ACCESS of a p1 write → mem_we drops immediately, no p1_ack, state IDLE. The next simultaneous request after release grants p0 first.
